// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipe_hazard_ctrl
// Description : Hazard, forwarding and flush controller for a 5-stage MIPS
//               pipeline. Keeps shadow EX/MEM/WB metadata and derives PC and
//               IF/ID enables, ID/EX bubbles, stage flushes, EX operand
//               forwarding selects and stall/flush event counters.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl #(
  parameter int REG_AW   = 5,   // register address width
  parameter int FWD_EN   = 1,   // 1: forwarding + load-use interlock, 0: full RAW interlock
  parameter int BR_STAGE = 3,   // 2: branch resolves in EX, 3: in MEM (other values illegal)
  parameter int CNT_W    = 32   // performance counter width
) (
  input  logic              CLOCK_IN,
  input  logic              RESET_N,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_rs_used,
  input  logic              id_rt_used,
  input  logic [REG_AW-1:0] id_dst,
  input  logic              id_regwrite,
  input  logic              id_memread,
  input  logic              br_taken,
  input  logic              cnt_clr,
  output logic              pc_en,
  output logic              if_id_en,
  output logic              id_ex_bubble,
  output logic              flush_if_id,
  output logic              flush_id_ex,
  output logic              flush_ex_mem,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef struct packed {
    logic              v;
    logic [REG_AW-1:0] dst;
    logic              rw;
    logic              mr;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic              rs_u;
    logic              rt_u;
  } shadow_t;

  shadow_t          r_ex, r_mem, r_wb;
  shadow_t          w_id;
  logic             w_ex_wr, w_mem_wr, w_wb_wr;
  logic             w_hazard, w_flush, w_flush_em, w_stall;
  logic [1:0]       w_fwd_a, w_fwd_b;
  logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;
  logic             w_unused;

  // A used source register that equals the destination of a live writer.
  function automatic logic f_hit(input logic used, input logic [REG_AW-1:0] src,
                                 input logic wr, input logic [REG_AW-1:0] dst);
    return used && wr && (src == dst);
  endfunction

  // EX operand select: the younger producer (MEM) wins over WB.
  function automatic logic [1:0] f_fwd_sel(input logic used, input logic [REG_AW-1:0] src,
                                           input logic mem_wr, input logic [REG_AW-1:0] mem_dst,
                                           input logic wb_wr, input logic [REG_AW-1:0] wb_dst);
    if (f_hit(used, src, mem_wr, mem_dst)) return 2'b01;
    if (f_hit(used, src, wb_wr, wb_dst))   return 2'b10;
    return 2'b00;
  endfunction

  assign w_id = '{v: id_valid, dst: id_dst, rw: id_regwrite, mr: id_memread,
                  rs: id_rs, rt: id_rt, rs_u: id_rs_used, rt_u: id_rt_used};

  // Register 0 is hard-wired, so a write to it is never a real producer.
  assign w_ex_wr  = r_ex.v  & r_ex.rw  & (r_ex.dst  != '0);
  assign w_mem_wr = r_mem.v & r_mem.rw & (r_mem.dst != '0);
  assign w_wb_wr  = r_wb.v  & r_wb.rw  & (r_wb.dst  != '0);

  generate
    if (FWD_EN != 0) begin : g_fwd
      logic w_rs_ex, w_rt_ex;
      assign w_rs_ex  = id_valid & f_hit(id_rs_used, id_rs, w_ex_wr, r_ex.dst);
      assign w_rt_ex  = id_valid & f_hit(id_rt_used, id_rt, w_ex_wr, r_ex.dst);
      // Only a load directly ahead cannot be bypassed: one bubble.
      assign w_hazard = (w_rs_ex | w_rt_ex) & r_ex.mr;
      assign w_fwd_a  = f_fwd_sel(r_ex.v & r_ex.rs_u, r_ex.rs, w_mem_wr, r_mem.dst, w_wb_wr, r_wb.dst);
      assign w_fwd_b  = f_fwd_sel(r_ex.v & r_ex.rt_u, r_ex.rt, w_mem_wr, r_mem.dst, w_wb_wr, r_wb.dst);
    end else begin : g_nofwd
      logic [5:0] w_hits;
      assign w_hits = {f_hit(id_rs_used, id_rs, w_ex_wr,  r_ex.dst),
                       f_hit(id_rt_used, id_rt, w_ex_wr,  r_ex.dst),
                       f_hit(id_rs_used, id_rs, w_mem_wr, r_mem.dst),
                       f_hit(id_rt_used, id_rt, w_mem_wr, r_mem.dst),
                       f_hit(id_rs_used, id_rs, w_wb_wr,  r_wb.dst),
                       f_hit(id_rt_used, id_rt, w_wb_wr,  r_wb.dst)};
      // Without bypass paths the consumer waits until the producer retires.
      assign w_hazard = id_valid & (|w_hits);
      assign w_fwd_a  = 2'b00;
      assign w_fwd_b  = 2'b00;
    end

    if (BR_STAGE == 2) begin : g_br_ex
      assign w_flush    = br_taken & r_ex.v;
      assign w_flush_em = 1'b0;
    end else begin : g_br_mem
      assign w_flush    = br_taken & r_mem.v;
      assign w_flush_em = w_flush;
    end
  endgenerate

  // A taken branch squashes the stalled instruction anyway, so it wins.
  assign w_stall = w_hazard & ~w_flush;

  assign pc_en        = ~w_stall;
  assign if_id_en     = ~w_stall;
  assign id_ex_bubble = w_stall;
  assign flush_if_id  = w_flush;
  assign flush_id_ex  = w_flush;
  assign flush_ex_mem = w_flush_em;
  assign fwd_a        = w_fwd_a;
  assign fwd_b        = w_fwd_b;
  assign stall_cnt    = r_stall_cnt;
  assign flush_cnt    = r_flush_cnt;

  // Source fields of older stages are carried for completeness only.
  assign w_unused = ^{r_ex.rs, r_ex.rt, r_ex.rs_u, r_ex.rt_u,
                      r_mem.mr, r_mem.rs, r_mem.rt, r_mem.rs_u, r_mem.rt_u,
                      r_wb.mr, r_wb.rs, r_wb.rt, r_wb.rs_u, r_wb.rt_u};

  // Shadow pipeline advance; bubbles and flushed slots enter as all-zero.
  always_ff @(posedge CLOCK_IN or negedge RESET_N) begin
    if (!RESET_N) begin
      r_ex  <= '0;
      r_mem <= '0;
      r_wb  <= '0;
    end else begin
      r_wb  <= r_mem;
      r_mem <= w_flush_em ? '0 : r_ex;
      r_ex  <= (w_stall | w_flush) ? '0 : w_id;
    end
  end

  // Saturating event counters; clear beats increment.
  always_ff @(posedge CLOCK_IN or negedge RESET_N) begin
    if (!RESET_N) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else if (cnt_clr) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_stall && (r_stall_cnt != c_cnt_max)) r_stall_cnt <= r_stall_cnt + c_cnt_one;
      if (w_flush && (r_flush_cnt != c_cnt_max)) r_flush_cnt <= r_flush_cnt + c_cnt_one;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_hazard_ctrl
// Description : Self-checking bench for pipe_hazard_ctrl. Three instances
//               (forwarding/MEM branch, interlock/MEM branch with 4-bit
//               counters, forwarding/EX branch) share directed stimulus and
//               are checked each cycle against an instruction-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_hazard_ctrl;

  typedef struct packed {
    logic       v;
    logic [4:0] dst;
    logic       rw;
    logic       mr;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       rsu;
    logic       rtu;
  } ins_t;

  logic       CLOCK_IN = 1'b0;
  logic       RESET_N  = 1'b1;
  ins_t       cur      = '0;
  logic       br       = 1'b0;
  logic       clr      = 1'b0;

  logic       pc_en_o[3], ifid_o[3], bub_o[3], fif_o[3], fie_o[3], fem_o[3];
  logic [1:0] fa_o[3], fb_o[3];
  logic [31:0] sc0, fc0;
  logic [3:0]  sc1, fc1;
  logic [7:0]  sc2, fc2;

  int n_checks = 0;
  int n_err    = 0;

  always #5 CLOCK_IN = ~CLOCK_IN;

  pipe_hazard_ctrl #(.REG_AW(5), .FWD_EN(1), .BR_STAGE(3), .CNT_W(32)) u0 (
    .CLOCK_IN(CLOCK_IN), .RESET_N(RESET_N), .id_valid(cur.v), .id_rs(cur.rs), .id_rt(cur.rt),
    .id_rs_used(cur.rsu), .id_rt_used(cur.rtu), .id_dst(cur.dst), .id_regwrite(cur.rw),
    .id_memread(cur.mr), .br_taken(br), .cnt_clr(clr), .pc_en(pc_en_o[0]), .if_id_en(ifid_o[0]),
    .id_ex_bubble(bub_o[0]), .flush_if_id(fif_o[0]), .flush_id_ex(fie_o[0]), .flush_ex_mem(fem_o[0]),
    .fwd_a(fa_o[0]), .fwd_b(fb_o[0]), .stall_cnt(sc0), .flush_cnt(fc0));

  pipe_hazard_ctrl #(.REG_AW(5), .FWD_EN(0), .BR_STAGE(3), .CNT_W(4)) u1 (
    .CLOCK_IN(CLOCK_IN), .RESET_N(RESET_N), .id_valid(cur.v), .id_rs(cur.rs), .id_rt(cur.rt),
    .id_rs_used(cur.rsu), .id_rt_used(cur.rtu), .id_dst(cur.dst), .id_regwrite(cur.rw),
    .id_memread(cur.mr), .br_taken(br), .cnt_clr(clr), .pc_en(pc_en_o[1]), .if_id_en(ifid_o[1]),
    .id_ex_bubble(bub_o[1]), .flush_if_id(fif_o[1]), .flush_id_ex(fie_o[1]), .flush_ex_mem(fem_o[1]),
    .fwd_a(fa_o[1]), .fwd_b(fb_o[1]), .stall_cnt(sc1), .flush_cnt(fc1));

  pipe_hazard_ctrl #(.REG_AW(5), .FWD_EN(1), .BR_STAGE(2), .CNT_W(8)) u2 (
    .CLOCK_IN(CLOCK_IN), .RESET_N(RESET_N), .id_valid(cur.v), .id_rs(cur.rs), .id_rt(cur.rt),
    .id_rs_used(cur.rsu), .id_rt_used(cur.rtu), .id_dst(cur.dst), .id_regwrite(cur.rw),
    .id_memread(cur.mr), .br_taken(br), .cnt_clr(clr), .pc_en(pc_en_o[2]), .if_id_en(ifid_o[2]),
    .id_ex_bubble(bub_o[2]), .flush_if_id(fif_o[2]), .flush_id_ex(fie_o[2]), .flush_ex_mem(fem_o[2]),
    .fwd_a(fa_o[2]), .fwd_b(fb_o[2]), .stall_cnt(sc2), .flush_cnt(fc2));

  // ---------------- configuration of each instance ----------------
  function automatic logic fe_of(int k);  return k != 1;           endfunction
  function automatic int   bs_of(int k);  return (k == 2) ? 2 : 3; endfunction
  function automatic logic [63:0] max_of(int k);
    case (k)
      0:       return 64'hFFFF_FFFF;
      1:       return 64'd15;
      default: return 64'd255;
    endcase
  endfunction

  function automatic logic [63:0] sc_of(int k);
    case (k)
      0:       return 64'(sc0);
      1:       return 64'(sc1);
      default: return 64'(sc2);
    endcase
  endfunction
  function automatic logic [63:0] fc_of(int k);
    case (k)
      0:       return 64'(fc0);
      1:       return 64'(fc1);
      default: return 64'(fc2);
    endcase
  endfunction
  function automatic logic [9:0] ctrl_of(int k);
    return {pc_en_o[k], ifid_o[k], bub_o[k], fif_o[k], fie_o[k], fem_o[k], fa_o[k], fb_o[k]};
  endfunction
  function automatic logic [2:0] fl_of(int k);
    return {fif_o[k], fie_o[k], fem_o[k]};
  endfunction

  // ---------------- instruction constructors ----------------
  localparam ins_t NOPI = '0;
  function automatic ins_t alu(int d, int s, int t);
    ins_t x = '0;
    x.v = 1'b1; x.dst = 5'(d); x.rw = 1'b1; x.rs = 5'(s); x.rt = 5'(t); x.rsu = 1'b1; x.rtu = 1'b1;
    return x;
  endfunction
  function automatic ins_t lw(int d, int s);
    ins_t x = '0;
    x.v = 1'b1; x.dst = 5'(d); x.rw = 1'b1; x.mr = 1'b1; x.rs = 5'(s); x.rsu = 1'b1;
    return x;
  endfunction
  function automatic ins_t brn(int s, int t);
    ins_t x = '0;
    x.v = 1'b1; x.rs = 5'(s); x.rt = 5'(t); x.rsu = 1'b1; x.rtu = 1'b1;
    return x;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- instruction-level model ----------------
  // mp[k][age]: age 0 is the instruction one slot ahead of ID, 1 two ahead, 2 three ahead.
  ins_t        mp[3][3];
  logic [63:0] esc[3], efc[3];

  function automatic logic is_writer(ins_t x);
    return x.v && x.rw && (x.dst != 5'd0);
  endfunction
  function automatic logic reads(ins_t c, logic [4:0] r);
    return (c.rsu && c.rs == r) || (c.rtu && c.rt == r);
  endfunction
  // Nearest older producer of the EX operand supplies it.
  function automatic logic [1:0] fwd_of(int k, logic [4:0] r, logic used);
    if (!fe_of(k) || !mp[k][0].v || !used) return 2'b00;
    if (is_writer(mp[k][1]) && mp[k][1].dst == r) return 2'b01;
    if (is_writer(mp[k][2]) && mp[k][2].dst == r) return 2'b10;
    return 2'b00;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      for (int a = 0; a < 3; a++) mp[k][a] = '0;
      esc[k] = '0;
      efc[k] = '0;
    end
  endtask

  initial begin
    ins_t        nx[3][3];
    logic [63:0] nsc[3], nfc[3];
    model_reset();
    forever begin
      @(negedge CLOCK_IN);
      if (!RESET_N) model_reset();
      for (int k = 0; k < 3; k++) begin
        logic       hz, tk, st;
        logic [9:0] ex;
        hz = 1'b0;
        if (cur.v)
          for (int a = 0; a < 3; a++)
            if (is_writer(mp[k][a]) && reads(cur, mp[k][a].dst))
              if (!fe_of(k) || (a == 0 && mp[k][a].mr)) hz = 1'b1;
        tk = br && mp[k][bs_of(k) - 2].v;
        st = hz && !tk;
        ex = {!st, !st, st, tk, tk, tk && (bs_of(k) == 3),
              fwd_of(k, mp[k][0].rs, mp[k][0].rsu), fwd_of(k, mp[k][0].rt, mp[k][0].rtu)};
        chk($sformatf("ctrl cfg%0d", k), 64'(ctrl_of(k)), 64'(ex));
        chk($sformatf("stall_cnt cfg%0d", k), sc_of(k), esc[k]);
        chk($sformatf("flush_cnt cfg%0d", k), fc_of(k), efc[k]);
        nx[k][2] = mp[k][1];
        nx[k][1] = (tk && bs_of(k) == 3) ? '0 : mp[k][0];
        nx[k][0] = (st || tk) ? '0 : cur;
        nsc[k] = clr ? 64'd0 : ((st && esc[k] != max_of(k)) ? esc[k] + 64'd1 : esc[k]);
        nfc[k] = clr ? 64'd0 : ((tk && efc[k] != max_of(k)) ? efc[k] + 64'd1 : efc[k]);
      end
      @(posedge CLOCK_IN);
      if (RESET_N) begin
        for (int k = 0; k < 3; k++) begin
          for (int a = 0; a < 3; a++) mp[k][a] = nx[k][a];
          esc[k] = nsc[k];
          efc[k] = nfc[k];
        end
      end else begin
        model_reset();
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(ins_t i, logic b = 1'b0, logic c = 1'b0);
    @(posedge CLOCK_IN);
    #1;
    cur = i; br = b; clr = c;
    #3;
  endtask

  task automatic rst(ins_t first);
    RESET_N = 1'b0; cur = NOPI; br = 1'b0; clr = 1'b0;
    repeat (2) @(posedge CLOCK_IN);
    #1;
    RESET_N = 1'b1; cur = first;
    #3;
  endtask

  initial begin
    #1 RESET_N = 1'b0;
    rst(NOPI);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("lit reset ctrl d%0d", k), 64'(ctrl_of(k)), 64'h300);
      chk($sformatf("lit reset stall_cnt d%0d", k), sc_of(k), 64'd0);
    end

    // back-to-back ALU dependency: bypass from MEM
    step(alu(3, 1, 2));
    step(alu(4, 3, 5));
    chk("lit b2b no stall d0", 64'(pc_en_o[0]), 64'd1);
    chk("lit b2b raw stall d1", 64'(pc_en_o[1]), 64'd0);
    step(NOPI);
    chk("lit b2b fwd_a d0", 64'(fa_o[0]), 64'd1);
    chk("lit b2b fwd_b d0", 64'(fb_o[0]), 64'd0);
    repeat (3) step(NOPI);

    // one independent instruction between: bypass from WB
    rst(NOPI);
    step(alu(3, 1, 2));
    step(alu(9, 10, 11));
    step(alu(4, 3, 5));
    chk("lit gap no stall d0", 64'(pc_en_o[0]), 64'd1);
    step(NOPI);
    chk("lit gap fwd_a d0", 64'(fa_o[0]), 64'd2);

    // load-use: one bubble, then WB bypass
    rst(NOPI);
    step(lw(2, 1));
    step(alu(6, 2, 7));
    chk("lit loaduse stall d0", 64'({pc_en_o[0], bub_o[0]}), 64'b01);
    step(alu(6, 2, 7));
    chk("lit loaduse released d0", 64'(pc_en_o[0]), 64'd1);
    step(NOPI);
    chk("lit loaduse fwd_a d0", 64'(fa_o[0]), 64'd2);
    chk("lit loaduse stall_cnt d0", sc_of(0), 64'd1);

    // no forwarding: three stall cycles for an adjacent producer
    rst(NOPI);
    step(alu(3, 1, 2));
    repeat (3) step(alu(4, 3, 3));
    step(alu(4, 3, 3));
    chk("lit raw released d1", 64'(pc_en_o[1]), 64'd1);
    chk("lit raw stall_cnt d1", sc_of(1), 64'd3);
    step(NOPI);
    chk("lit raw fwd d1", 64'({fa_o[1], fb_o[1]}), 64'd0);

    // register 0 and unused sources never interlock
    rst(NOPI);
    step(alu(0, 1, 2));
    step(alu(5, 0, 0));
    chk("lit r0 no stall d1", 64'(pc_en_o[1]), 64'd1);
    step(NOPI);
    chk("lit r0 no fwd d0", 64'({fa_o[0], fb_o[0]}), 64'd0);
    step(alu(7, 1, 2));
    step('{v: 1'b1, dst: 5'd8, rw: 1'b1, mr: 1'b0, rs: 5'd7, rt: 5'd8, rsu: 1'b0, rtu: 1'b1});
    chk("lit unused src d1", 64'(pc_en_o[1]), 64'd1);

    // taken branches in MEM and EX
    rst(NOPI);
    step(brn(1, 2));
    step(NOPI);
    step(NOPI, 1'b1);
    chk("lit br mem flush d0", 64'(fl_of(0)), 64'b111);
    chk("lit br mem flush d1", 64'(fl_of(1)), 64'b111);
    chk("lit br ex ignored d2", 64'(fl_of(2)), 64'b000);
    step(brn(1, 2));
    step(NOPI, 1'b1);
    chk("lit br ex flush d2", 64'(fl_of(2)), 64'b110);
    chk("lit br mem ignored d0", 64'(fl_of(0)), 64'b000);
    step(NOPI);
    chk("lit flush_cnt d0", fc_of(0), 64'd1);
    chk("lit flush_cnt d2", fc_of(2), 64'd1);
    step(brn(1, 2));
    step(brn(3, 4), 1'b1);
    step(NOPI, 1'b1);
    chk("lit flushed slot ignored d2", 64'(fif_o[2]), 64'd0);
    step(NOPI);
    chk("lit flush_cnt b2b d2", fc_of(2), 64'd2);
    chk("lit flush_cnt b2b d0", fc_of(0), 64'd2);

    // flush overrides a simultaneous load-use stall
    rst(NOPI);
    step(lw(2, 1));
    step(alu(6, 2, 7), 1'b1);
    chk("lit flush over stall d2", 64'({pc_en_o[2], bub_o[2], fie_o[2]}), 64'b101);
    chk("lit stall no flush d0", 64'(pc_en_o[0]), 64'd0);

    // stall counter saturation, clear, and reset mid-stall
    rst(NOPI);
    for (int r = 0; r < 6; r++) begin
      step(alu(3, 1, 2));
      repeat (4) step(alu(4, 3, 5));
    end
    step(NOPI);
    chk("lit stall_cnt saturated d1", sc_of(1), 64'd15);
    step(alu(3, 1, 2));
    step(alu(4, 3, 5), 1'b0, 1'b1);
    step(alu(4, 3, 5));
    chk("lit stall_cnt cleared d1", sc_of(1), 64'd0);
    step(alu(4, 3, 5));
    chk("lit stall_cnt after clr d1", sc_of(1), 64'd1);
    chk("lit mid stall d1", 64'(pc_en_o[1]), 64'd0);
    RESET_N = 1'b0;
    #1;
    chk("lit async reset ctrl d1", 64'(ctrl_of(1)), 64'h300);
    chk("lit async reset stall_cnt d1", sc_of(1), 64'd0);
    rst(alu(4, 3, 5));
    chk("lit post reset no hazard d1", 64'(pc_en_o[1]), 64'd1);

    // reset mid-flush
    rst(NOPI);
    step(brn(1, 2));
    step(NOPI);
    step(NOPI, 1'b1);
    chk("lit pre reset flush d0", 64'(fl_of(0)), 64'b111);
    RESET_N = 1'b0;
    #1;
    chk("lit async reset flush d0", 64'(ctrl_of(0)), 64'h300);
    chk("lit async reset flush_cnt d0", fc_of(0), 64'd0);
    rst(NOPI);
    step(NOPI);

    repeat (2) @(posedge CLOCK_IN);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
`default_nettype wire
